serial_adder: RTL
=================

Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor. It is the sequential successor to the team's single-bit full-adder cell.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Processes DIGIT bits per clock through a registered carry.
- Returns sum, carry-out and signed overflow over a second valid/ready handshake.
- Used in area-constrained datapaths where a full-width ripple or carry-lookahead adder is too large.

Parameters:
WIDTH, 8, operand and sum width in bits (>=2).
DIGIT, 1, bits processed per clock. Must divide WIDTH; elaboration-time check fails otherwise.

Ports:
clk        in   1      single clock, all state changes on rising edge
rst        in   1      synchronous, active-high reset
in_valid   in   1      operands/mode valid
in_ready   out  1      block can accept operands
a          in   WIDTH  operand A
b          in   WIDTH  operand B
cin        in   1      carry-in (add) / borrow-in (sub)
sub        in   1      0: A+B+cin; 1: A-B-cin
out_valid  out  1      result valid
out_ready  in   1      consumer accepts result
sum        out  WIDTH  result, two's complement wrap
cout       out  1      raw carry out of MSB (sub: 1 = no borrow)
ovf        out  1      signed overflow
busy       out  1      high in RUN or DONE

Behaviour:
- Interface decision: one clock, clk; rst is synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, step counter=0, carry=0. Reset wins over every handshake in the same cycle. Reset mid-RUN or mid-DONE discards the operation; no out_valid is produced for it.
- STEPS = WIDTH/DIGIT. Counter width is clog2(STEPS), minimum 1.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch A.
    - latch B' = sub ? ~b : b.
    - carry = cin ^ sub.
    - count=0; go to RUN.
  - RUN: in_ready=0. Each cycle, the low DIGIT bits of A and B' plus carry go through digit_adder.
    - Result digit shifts into sum from the MSB side; A and B' shift right by DIGIT.
    - carry <= digit carry-out; count++.
    - On count==STEPS-1:
      - cout <= final carry.
      - ovf <= (carry into MSB) ^ (carry out of MSB).
      - go to DONE.
  - DONE: out_valid=1; sum/cout/ovf held stable. On out_ready, go to IDLE and drop out_valid next cycle.
- Latency: handshake accepted at edge E0 gives out_valid=1 after edge E(STEPS). For WIDTH=8, DIGIT=1 that is 8 cycles.
- Throughput: one result per STEPS+2 cycles. No acceptance while in DONE, even if out_ready=1 in the same cycle.
- Input changes while in_ready=0 are ignored. in_valid is not required to stay high after acceptance.
- out_ready outside DONE has no effect.
- sum/cout/ovf keep their last values in IDLE; they are undefined to the consumer when out_valid=0.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + ~cin.

Decomposition:
- serial_adder_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - function returning STEPS
  - counter-width constant helper
- One sub-module: digit_adder, combinational DIGIT-bit ripple adder. Ports x, y, ci, s, co, plus msb_ci (carry into its top bit, used for ovf).

Test Plan:
- WIDTH=8, DIGIT=1, add a=0x5A b=0x3C cin=0 -> after 8 cycles sum=0x96, cout=0, ovf=1.
- Add a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1, ovf=0. Add a=0x00 b=0x00 cin=1 -> sum=0x01, cout=0.
- Sub a=0x10 b=0x20 cin=0 -> sum=0xF0, cout=0, ovf=0. Sub a=0x80 b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle, then the next operand is accepted.
- Assert rst at RUN step 3 -> next cycle in_ready=1, out_valid=0, sum=0. No spurious result follows.
- WIDTH=16, DIGIT=4, add a=0x1234 b=0xEDCC -> out_valid 4 cycles after acceptance, sum=0x0000, cout=1, ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and elaboration-time helpers for the serial adder/subtractor.
//   - state_t        : control FSM encoding (IDLE, RUN, DONE)
//   - calc_steps     : number of digit steps per operation (WIDTH/DIGIT)
//   - calc_cnt_width : step counter width, clog2(steps) with a minimum of 1
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_cnt_width(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder
//   Combinational DIGIT-bit ripple-carry adder used once per clock by the
//   serial adder.
//   Ports:
//     x, y    : DIGIT-bit addend digits
//     ci      : carry into bit 0
//     s       : DIGIT-bit sum digit
//     co      : carry out of the top bit
//     msb_ci  : carry into the top bit (feeds signed-overflow detection)
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             msb_ci
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co     = c[DIGIT];
    assign msb_ci = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor processing DIGIT bits per clock through a
//   registered carry. Operands arrive over a valid/ready handshake; the
//   result (sum, cout, ovf) leaves over a second valid/ready handshake.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid, in_ready  : operand handshake
//     a, b, cin, sub      : operands, carry/borrow-in, 0=add 1=subtract
//     out_valid, out_ready: result handshake
//     sum, cout, ovf      : result, raw MSB carry-out, signed overflow
//     busy                : high while in RUN or DONE
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CW    = calc_cnt_width(STEPS);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder: WIDTH must be >= 2 and divisible by DIGIT");
    end

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co, dig_msb_ci;
    logic             accept, last_step;

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == RUN) && (cnt_q == CW'(STEPS - 1));

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x      (a_q[DIGIT-1:0]),
        .y      (b_q[DIGIT-1:0]),
        .ci     (carry_q),
        .s      (dig_s),
        .co     (dig_co),
        .msb_ci (dig_msb_ci)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath. Subtraction is folded into the operand latch: B is inverted
    // and the borrow-in becomes carry = ~cin, giving A + ~B + ~cin.
    // Sum digits enter from the MSB side so after STEPS shifts the first
    // digit computed sits in the least-significant position.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            sum_q   <= WIDTH'({dig_s, sum_q} >> DIGIT);
            carry_q <= dig_co;
            cnt_q   <= cnt_q + 1'b1;
            if (last_step) begin
                cout_q <= dig_co;
                ovf_q  <= dig_msb_ci ^ dig_co;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
